// File: rtl/cpu16_pkg.sv
// Shared widths and types for the 16-bit CPU debug blocks.
// Holds the register-dump FSM encoding and the dumped-word record.
package cpu16_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } dump_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] index;
    logic                  last;
  } dump_word_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Halts CPU writeback and streams r0..LAST_REG out one word per 2 cycles; first word 3 cycles after start.
// valid/ready output: a word holds stable until accepted, and the read of the next register waits for it.
module reg_dump_reader
  import cpu16_pkg::*;
#(
  parameter int LAST_REG = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  cpu_halt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(LAST_REG);

  dump_state_t           state;
  dump_state_t           state_nxt;
  logic [REG_ADDR_W-1:0] index;
  dump_word_t            word;
  logic                  word_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_READ;
      ST_READ: state_nxt = ST_SEND;
      ST_SEND: begin
        if (out_ready) begin
          state_nxt = word.last ? ST_FIN : ST_READ;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    cpu_halt = (state == ST_HALT) || (state == ST_READ) || (state == ST_SEND);
    done     = (state == ST_FIN);
    rd_addr  = ((state == ST_READ) || (state == ST_SEND)) ? index : '0;
  end

  // Index stops at LAST_IDX because the last word exits to FIN instead of advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      index    <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) index <= '0;
        end
        ST_READ: begin
          word.data  <= rd_data;
          word.index <= index;
          word.last  <= (index == LAST_IDX);
          word_vld   <= 1'b1;
        end
        ST_SEND: begin
          if (out_ready) begin
            word_vld <= 1'b0;
            if (!word.last) index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = word_vld;
  assign out_data  = word.data;
  assign out_index = word.index;
  assign out_last  = word.last;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a behavioural register file with a halt-gated
// write port feeds a LAST_REG=15 instance and a LAST_REG=0 instance.
module tb_reg_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start0;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_addr0;
  logic [15:0] rd_data;
  logic [15:0] rd_data0;
  logic        cpu_halt;
  logic        cpu_halt0;
  logic        out_valid;
  logic        out_valid0;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_data0;
  logic [3:0]  out_index;
  logic [3:0]  out_index0;
  logic        out_last;
  logic        out_last0;
  logic        busy;
  logic        busy0;
  logic        done;
  logic        done0;

  logic        cpu_we;
  logic [3:0]  cpu_waddr;
  logic [15:0] cpu_wdata;
  logic [15:0] regs [16];
  logic [15:0] exp_mem [16];

  int n_chk = 0;
  int n_err = 0;

  reg_dump_reader #(.LAST_REG(15)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_halt(cpu_halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  reg_dump_reader #(.LAST_REG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .cpu_halt(cpu_halt0), .out_valid(out_valid0), .out_ready(1'b1),
    .out_data(out_data0), .out_index(out_index0), .out_last(out_last0),
    .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  // CPU writeback is stalled by the main instance's halt.
  always @(posedge clk) begin
    if (cpu_we && !cpu_halt) regs[cpu_waddr] <= cpu_wdata;
  end

  assign rd_data  = regs[rd_addr];
  assign rd_data0 = regs[rd_addr0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_dump(input int stall_w, input int stall_n, input int repulse_w,
                         input int exp_done, input bit blk);
    int nword;
    int ndone;
    int done_cyc;
    int first_v;
    int stalled;
    nword = 0; ndone = 0; done_cyc = -1; first_v = -1; stalled = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (blk) begin
      cpu_waddr = 4'd6;
      cpu_wdata = 16'hDEAD;
    end
    chk("addr_in_halt", {28'd0, rd_addr}, 32'd0);
    for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
      out_ready = 1'b1;
      start = 1'b0;
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("rd_addr_send", {28'd0, rd_addr}, {28'd0, out_index});
        if (int'(out_index) == stall_w && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
          chk("stall_dat", {16'd0, out_data}, {16'd0, exp_mem[stall_w]});
          chk("stall_idx", {28'd0, out_index}, stall_w);
        end
        if (int'(out_index) == repulse_w) start = 1'b1;
        if (out_ready) begin
          chk("word_idx", {28'd0, out_index}, nword);
          chk("word_dat", {16'd0, out_data}, {16'd0, exp_mem[nword % 16]});
          chk("word_last", {31'd0, out_last}, {31'd0, (nword == 15)});
          nword++;
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        cpu_we = 1'b0;
        chk("halt_in_fin", {31'd0, cpu_halt}, 32'd0);
      end else if (done_cyc < 0) begin
        chk("halt_in_dump", {31'd0, cpu_halt}, 32'd1);
        chk("busy_in_dump", {31'd0, busy}, 32'd1);
      end
      tick();
    end
    out_ready = 1'b0;
    chk("first_valid_cyc", first_v, 3);
    chk("word_count", nword, 16);
    chk("done_count", ndone, 1);
    chk("done_cyc", done_cyc, exp_done);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int found;
    int ndone;
    int first_v;
    int done_cyc;
    clk = 1'b0; rst = 1'b1; start = 1'b0; start0 = 1'b0; out_ready = 1'b0;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_halt", {31'd0, cpu_halt}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_addr", {28'd0, rd_addr}, 0);
    chk("rst_data", {16'd0, out_data}, 0);

    for (int i = 0; i < 16; i++) begin
      cpu_we = 1'b1; cpu_waddr = 4'(i); cpu_wdata = 16'h1000 + 16'(i);
      exp_mem[i] = 16'h1000 + 16'(i);
      tick();
    end
    cpu_we = 1'b0;

    // Free-running, stalled, and re-pulsed dumps.
    do_dump(-1, 0, -1, 34, 1'b0);
    do_dump(3, 5, -1, 39, 1'b0);
    do_dump(-1, 0, 4, 34, 1'b0);

    // Single-register instance.
    first_v = -1; ndone = 0; done_cyc = -1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (out_valid0 && first_v < 0) begin
        first_v = cyc;
        chk("l0_dat", {16'd0, out_data0}, 32'h1000);
        chk("l0_idx", {28'd0, out_index0}, 0);
        chk("l0_last", {31'd0, out_last0}, 1);
      end
      if (done0) begin
        ndone++;
        done_cyc = cyc;
      end
      tick();
    end
    chk("l0_first_valid", first_v, 3);
    chk("l0_done_cyc", done_cyc, 4);
    chk("l0_done_count", ndone, 1);

    // Reset in the middle of the dump while word 7 is presented.
    found = 0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
      if (out_valid && out_index == 4'd7) found = 1;
      else tick();
    end
    chk("reach_idx7", found, 1);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_data", {16'd0, out_data}, 0);
    chk("mid_rst_idx", {28'd0, out_index}, 0);
    chk("mid_rst_last", {31'd0, out_last}, 0);
    chk("mid_rst_halt", {31'd0, cpu_halt}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_addr", {28'd0, rd_addr}, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("mid_rst_quiet", ndone, 0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {31'd0, busy}, 0);
    do_dump(-1, 0, -1, 34, 1'b0);

    // Write to r5 alongside start lands; later writes to r6 are held off.
    exp_mem[5] = 16'hBEEF;
    cpu_we = 1'b1; cpu_waddr = 4'd5; cpu_wdata = 16'hBEEF;
    do_dump(-1, 0, -1, 34, 1'b1);
    cpu_we = 1'b0;
    chk("r6_untouched", {16'd0, regs[6]}, 32'h1006);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
